// File: rtl/bp_me_stream_arb_pkg.sv
// Shared types for the BedRock stream arbiter: FSM states, the mem header
// layout and a safe clog2 helper for sizing index and counter fields.
package bp_me_stream_arb_pkg;

  localparam int paddr_width_gp     = 40;
  localparam int lce_id_width_gp    = 4;
  localparam int lce_assoc_gp       = 8;
  localparam int dword_width_gp     = 64;
  localparam int cce_block_width_gp = 512;

  typedef enum logic {
    e_idle,
    e_locked
  } bp_me_stream_arb_state_e;

  typedef struct packed {
    logic [3:0]                      msg_type;
    logic [3:0]                      subop;
    logic [paddr_width_gp-1:0]       addr;
    logic [2:0]                      size;
    logic [lce_id_width_gp-1:0]      lce_id;
    logic [$clog2(lce_assoc_gp)-1:0] way_id;
  } bp_bedrock_mem_header_s;

  localparam int xce_mem_msg_header_width_gp = $bits(bp_bedrock_mem_header_s);

  // Never returns 0, so single-entry quantities still get a 1-bit field
  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bp_me_stream_arb_buffer.sv
// Two-entry ready/valid FIFO that registers the arbiter's shared output channel.
// Ready depends only on the registered occupancy; a full buffer never bypasses.
module bp_me_stream_arb_buffer #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_and_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               ready_and_i
);

  logic [1:0][width_p-1:0] mem_r;
  logic                    wr_ptr_r, rd_ptr_r;
  logic [1:0]              count_r, count_n;
  logic                    enq, deq;

  assign ready_and_o = (count_r != 2'd2);
  assign v_o         = (count_r != 2'd0);
  assign data_o      = mem_r[rd_ptr_r];
  assign enq         = v_i & ready_and_o;
  assign deq         = v_o & ready_and_i;

  always_comb begin
    count_n = count_r;
    case ({enq, deq})
      2'b10:   count_n = count_r + 2'd1;
      2'b01:   count_n = count_r - 2'd1;
      default: count_n = count_r;
    endcase
  end

  // Entries are cleared on reset so the idle head reads as all zeros
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem_r    <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (enq) begin
        mem_r[wr_ptr_r] <= data_i;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (deq) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r <= count_n;
    end
  end

endmodule

// File: rtl/bp_me_stream_arb.sv
// Round-robin, wormhole-locked arbiter merging num_req_p BedRock streams onto
// one buffered output; a winner keeps the channel until its last beat transfers.
module bp_me_stream_arb
  import bp_me_stream_arb_pkg::*;
#(
  parameter  int num_req_p                   = 2,
  parameter  int stream_data_width_p         = dword_width_gp,
  parameter  int block_width_p               = cce_block_width_gp,
  localparam int xce_mem_msg_header_width_lp = xce_mem_msg_header_width_gp,
  localparam int stream_words_lp             = block_width_p / stream_data_width_p,
  localparam int req_id_width_lp             = safe_clog2(num_req_p),
  localparam int beat_cnt_width_lp           = safe_clog2(stream_words_lp + 1)
) (
  input  logic                                             clk_i,
  input  logic                                             reset_n_i,
  input  logic [num_req_p*xce_mem_msg_header_width_lp-1:0] in_header_i,
  input  logic [num_req_p*stream_data_width_p-1:0]         in_data_i,
  input  logic [num_req_p-1:0]                             in_v_i,
  input  logic [num_req_p-1:0]                             in_last_i,
  output logic [num_req_p-1:0]                             in_ready_and_o,
  output logic [xce_mem_msg_header_width_lp-1:0]           out_header_o,
  output logic [stream_data_width_p-1:0]                   out_data_o,
  output logic                                             out_last_o,
  output logic [req_id_width_lp-1:0]                       out_src_o,
  output logic                                             out_v_o,
  input  logic                                             out_ready_and_i,
  output logic                                             err_o
);

  localparam int hw_lp        = xce_mem_msg_header_width_lp;
  localparam int buf_width_lp = req_id_width_lp + 1 + hw_lp + stream_data_width_p;

  bp_me_stream_arb_state_e state_r, state_n;

  logic [req_id_width_lp-1:0]   grant_r, rr_ptr_r, pick_id, sel_id, next_ptr;
  logic [beat_cnt_width_lp-1:0] beat_cnt_r;
  logic [hw_lp-1:0]             hdr_r, sel_hdr;
  logic [stream_data_width_p-1:0] sel_data;
  logic                         err_r, pick_v, sel_v, sel_last, xfer, buf_ready;
  logic                         over_err, hdr_err;
  logic [buf_width_lp-1:0]      buf_data_li, buf_data_lo;

  logic [hw_lp-1:0]               hdr_arr  [num_req_p];
  logic [stream_data_width_p-1:0] data_arr [num_req_p];

  always_comb begin
    for (int i = 0; i < num_req_p; i++) begin
      hdr_arr[i]  = in_header_i[i*hw_lp +: hw_lp];
      data_arr[i] = in_data_i[i*stream_data_width_p +: stream_data_width_p];
    end
  end

  // Priority-rotate: walk offsets from far to near so the nearest valid to rr_ptr_r wins
  always_comb begin
    int idx;
    idx     = 0;
    pick_v  = 1'b0;
    pick_id = '0;
    for (int i = num_req_p - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_r) + i;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (in_v_i[idx]) begin
        pick_v  = 1'b1;
        pick_id = req_id_width_lp'(idx);
      end
    end
  end

  assign sel_id   = (state_r == e_locked) ? grant_r : pick_id;
  assign sel_v    = (state_r == e_locked) ? in_v_i[grant_r] : pick_v;
  assign sel_last = in_last_i[sel_id];
  assign sel_hdr  = hdr_arr[sel_id];
  assign sel_data = data_arr[sel_id];
  assign xfer     = sel_v & buf_ready;
  assign next_ptr = (sel_id == req_id_width_lp'(num_req_p - 1))
                  ? '0 : sel_id + req_id_width_lp'(1);

  assign over_err = xfer & ~sel_last & (beat_cnt_r >= beat_cnt_width_lp'(stream_words_lp));
  assign hdr_err  = xfer & (state_r == e_locked) & (sel_hdr != hdr_r);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= e_idle;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_idle:   if (xfer & ~sel_last) state_n = e_locked;
      e_locked: if (xfer &  sel_last) state_n = e_idle;
      default:  state_n = e_idle;
    endcase
  end

  always_comb begin
    in_ready_and_o = '0;
    if (state_r == e_locked)  in_ready_and_o[grant_r] = buf_ready;
    else if (pick_v)          in_ready_and_o[pick_id] = buf_ready;
  end

  // The beat counter saturates one past the limit so a runaway message cannot wrap it
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      grant_r    <= '0;
      rr_ptr_r   <= '0;
      beat_cnt_r <= '0;
      hdr_r      <= '0;
      err_r      <= 1'b0;
    end else begin
      err_r <= err_r | over_err | hdr_err;
      if (xfer) begin
        if (state_r == e_idle) begin
          if (sel_last) begin
            rr_ptr_r <= next_ptr;
          end else begin
            grant_r    <= sel_id;
            beat_cnt_r <= beat_cnt_width_lp'(1);
            hdr_r      <= sel_hdr;
          end
        end else if (sel_last) begin
          rr_ptr_r   <= next_ptr;
          beat_cnt_r <= '0;
        end else if (beat_cnt_r <= beat_cnt_width_lp'(stream_words_lp)) begin
          beat_cnt_r <= beat_cnt_r + beat_cnt_width_lp'(1);
        end
      end
    end
  end

  assign err_o       = err_r;
  assign buf_data_li = {sel_id, sel_last, sel_hdr, sel_data};

  bp_me_stream_arb_buffer #(
    .width_p (buf_width_lp)
  ) u_buffer (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .data_i      (buf_data_li),
    .v_i         (sel_v),
    .ready_and_o (buf_ready),
    .data_o      (buf_data_lo),
    .v_o         (out_v_o),
    .ready_and_i (out_ready_and_i)
  );

  assign {out_src_o, out_last_o, out_header_o, out_data_o} = buf_data_lo;

endmodule

// File: tb/tb_bp_me_stream_arb.sv
// Directed bench for bp_me_stream_arb: alternation, locking, backpressure,
// protocol errors and async reset, with hand-computed expectations.
module tb_bp_me_stream_arb;
  import bp_me_stream_arb_pkg::*;

  localparam int N = 2;
  localparam int W = 64;
  localparam int H = xce_mem_msg_header_width_gp;

  logic           clk, reset_n;
  logic [N*H-1:0] in_header;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_v, in_last, in_ready;
  logic [H-1:0]   out_header;
  logic [W-1:0]   out_data;
  logic           out_last, out_v, out_ready, err;
  logic [0:0]     out_src;

  logic [H-1:0]   hA, hB, hC;
  int             errors, checks;

  bp_me_stream_arb #(
    .num_req_p           (N),
    .stream_data_width_p (W),
    .block_width_p       (512)
  ) dut (
    .clk_i           (clk),
    .reset_n_i       (reset_n),
    .in_header_i     (in_header),
    .in_data_i       (in_data),
    .in_v_i          (in_v),
    .in_last_i       (in_last),
    .in_ready_and_o  (in_ready),
    .out_header_o    (out_header),
    .out_data_o      (out_data),
    .out_last_o      (out_last),
    .out_src_o       (out_src),
    .out_v_o         (out_v),
    .out_ready_and_i (out_ready),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int r, input logic v, input logic last,
                               input logic [H-1:0] hdr, input logic [W-1:0] data);
    in_v[r]            = v;
    in_last[r]         = last;
    in_header[r*H +: H] = hdr;
    in_data[r*W +: W]   = data;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    reset_n   = 1'b0;
    in_v      = '0;
    in_last   = '0;
    out_ready = 1'b1;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    errors = 0; checks = 0;
    clk = 1'b0; reset_n = 1'b0; out_ready = 1'b1;
    in_v = '0; in_last = '0; in_header = '0; in_data = '0;
    hA = '0; hA[15:0] = 16'hA5A5;
    hB = '0; hB[15:0] = 16'hB0B0;
    hC = '0; hC[15:0] = 16'hC3C3;
    step(); step();

    checkOutput("rst_out_v",  out_v, 0);
    checkOutput("rst_err",    err, 0);
    checkOutput("rst_last",   out_last, 0);
    checkOutput("rst_src",    out_src, 0);
    checkOutput("rst_ready",  in_ready, 0);

    // Single-beat alternation
    applyStimulus(0, 1, 1, hA, 64'hD0);
    applyStimulus(1, 1, 1, hB, 64'hD1);
    reset_n = 1'b1;
    #1;
    checkOutput("alt_ready0", in_ready, 2'b01);
    for (int k = 0; k < 4; k++) begin
      step();
      checkOutput("alt_v",    out_v, 1);
      checkOutput("alt_src",  out_src, k % 2);
      checkOutput("alt_data", out_data, (k % 2) ? 64'hD1 : 64'hD0);
    end
    applyStimulus(0, 0, 0, hA, 0);
    applyStimulus(1, 0, 0, hB, 0);
    step();
    checkOutput("alt_drain", out_v, 0);

    // Lock: req1 sends 4 beats, req0 competes from beat 2
    doReset();
    applyStimulus(1, 1, 0, hB, 64'hA1);
    #1;
    checkOutput("lock_rdy1", in_ready, 2'b10);
    step();
    for (int b = 1; b < 4; b++) begin
      applyStimulus(1, 1, b == 3, hB, 64'hA1 + b);
      if (b == 1) applyStimulus(0, 1, 1, hA, 64'hB0);
      #1;
      checkOutput("lock_rdy",  in_ready, 2'b10);
      checkOutput("lock_src",  out_src, 1);
      checkOutput("lock_data", out_data, 64'hA1 + b - 1);
      step();
    end
    applyStimulus(1, 0, 0, hB, 0);
    #1;
    checkOutput("lock_data4", out_data, 64'hA4);
    checkOutput("lock_last4", out_last, 1);
    checkOutput("lock_rdy0",  in_ready, 2'b01);
    step();
    checkOutput("lock_nsrc",  out_src, 0);
    checkOutput("lock_ndata", out_data, 64'hB0);
    applyStimulus(0, 0, 0, hA, 0);
    step();
    checkOutput("lock_drain", out_v, 0);
    checkOutput("lock_err",   err, 0);

    // Backpressure: buffer fills after two beats, no bypass on release
    doReset();
    out_ready = 1'b0;
    applyStimulus(0, 1, 1, hA, 64'hC0);
    #1;
    checkOutput("bp_rdy1", in_ready, 2'b01);
    step();
    applyStimulus(0, 1, 1, hA, 64'hC1);
    #1;
    checkOutput("bp_rdy2", in_ready, 2'b01);
    step();
    applyStimulus(0, 1, 1, hA, 64'hC2);
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput("bp_full",   in_ready, 2'b00);
      checkOutput("bp_v",      out_v, 1);
      checkOutput("bp_stable", out_data, 64'hC0);
      step();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_nobypass", in_ready, 2'b00);
    step();
    checkOutput("bp_d1",  out_data, 64'hC1);
    checkOutput("bp_rdy", in_ready, 2'b01);
    step();
    checkOutput("bp_d2", out_data, 64'hC2);
    applyStimulus(0, 0, 0, hA, 0);
    step();
    checkOutput("bp_drain", out_v, 0);

    // Overlong message: 9 beats without last on an 8-beat block
    doReset();
    for (int b = 1; b <= 9; b++) begin
      applyStimulus(0, 1, 0, hA, 64'(b));
      step();
      checkOutput("ovf_err", err, b >= 9);
    end
    checkOutput("ovf_data", out_data, 64'd9);
    applyStimulus(0, 1, 1, hA, 64'd10);
    step();
    applyStimulus(0, 0, 0, hA, 0);
    step(); step();
    checkOutput("ovf_sticky", err, 1);

    // Header change mid-message
    doReset();
    checkOutput("hdr_rst", err, 0);
    applyStimulus(1, 1, 0, hB, 64'hE1);
    step();
    checkOutput("hdr_ok1", err, 0);
    applyStimulus(1, 1, 0, hB, 64'hE2);
    step();
    checkOutput("hdr_ok2", err, 0);
    applyStimulus(1, 1, 0, hC, 64'hE3);
    step();
    checkOutput("hdr_err",  err, 1);
    checkOutput("hdr_data", out_data, 64'hE3);
    applyStimulus(1, 1, 1, hC, 64'hE4);
    step();
    checkOutput("hdr_sticky", err, 1);
    applyStimulus(1, 0, 0, hB, 0);
    step();

    // Async reset during beat 2 of a req1 message
    applyStimulus(1, 1, 0, hB, 64'hF1);
    step();
    applyStimulus(1, 1, 0, hB, 64'hF2);
    applyStimulus(0, 1, 1, hA, 64'h60);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_v",   out_v, 0);
    checkOutput("arst_err", err, 0);
    step();
    reset_n = 1'b1;
    #1;
    checkOutput("arst_rr", in_ready, 2'b01);
    step();
    checkOutput("arst_src",  out_src, 0);
    checkOutput("arst_data", out_data, 64'h60);
    applyStimulus(0, 0, 0, hA, 0);
    applyStimulus(1, 0, 0, hB, 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bp_me_stream_arb.md
# bp_me_stream_arb

Round-robin, wormhole-locked arbiter that shares one outbound BedRock Stream channel among `num_req_p` inbound BedRock Stream requesters. Once a requester wins, its grant is held until its `last` beat transfers, so multi-beat messages are never interleaved. The arbiter sits in front of a `bp_me_stream_pump_in`-style consumer, for example at a memory-side or I/O-side merge point. A two-entry output buffer registers the shared channel.

## Interface
- `bp_params_p`, `e_bp_default_cfg`: processor config; supplies `paddr_width_p`, `lce_id_width_p`, `lce_assoc_p`.
- `num_req_p`, 2: number of requesters; must be ≥2.
- `stream_data_width_p`, `dword_width_gp`: beat data width.
- `block_width_p`, `cce_block_width_p`: maximum message payload.
- `stream_words_lp` (local): `block_width_p/stream_data_width_p`.
- `req_id_width_lp` (local): `BSG_SAFE_CLOG2(num_req_p)`.
- `clk_i` in 1: clock.
- `reset_n_i` in 1: reset, asynchronous assert, active-low. This is the block's one clock and one reset.
- `in_header_i` in `num_req_p*xce_mem_msg_header_width_lp`: per-requester header, held constant across a message.
- `in_data_i` in `num_req_p*stream_data_width_p`: per-requester beat data.
- `in_v_i` in `num_req_p`: beat valid.
- `in_last_i` in `num_req_p`: final beat of the message.
- `in_ready_and_o` out `num_req_p`: beat accepted when `v & ready_and`.
- `out_header_o` out `xce_mem_msg_header_width_lp`: buffered header.
- `out_data_o` out `stream_data_width_p`: buffered data.
- `out_last_o` out 1: buffered last flag.
- `out_src_o` out `req_id_width_lp`: requester index of the buffered beat.
- `out_v_o` out 1: output valid.
- `out_ready_and_i` in 1: downstream ready.
- `err_o` out 1: sticky protocol error.

## Operation
FSM states are `e_idle` and `e_locked`.

**`e_idle`**
- Combinational round-robin pick among `in_v_i`, starting at `rr_ptr_r`.
- The winner `g` gets `in_ready_and_o[g] = buf_ready`. All other requesters get 0.
- On a transfer with `in_last_i[g]=0`: set `grant_r=g`, go to `e_locked`, set `beat_cnt_r=1`.
- On a transfer with `in_last_i[g]=1` (single-beat message): stay in `e_idle`, set `rr_ptr_r=g+1` (mod `num_req_p`).

**`e_locked`**
- Only `grant_r` sees ready. Other requesters stall even if valid.
- Each transfer increments `beat_cnt_r`.
- A transfer with last: go to `e_idle`, `rr_ptr_r=grant_r+1`, `beat_cnt_r=0`.
- `in_v_i[grant_r]` low inserts bubbles. The lock is held indefinitely.

**Output buffer**
- Two entries, FIFO order. Each entry is `{src, last, header, data}`.
- `buf_ready` means not full.
- The head is presented on the `out_*` ports. Dequeue happens on `out_v_o & out_ready_and_i`.
- Enqueue and dequeue in the same cycle are allowed when full: the dequeue frees the slot combinationally only if the implementation chooses bypass. **Decided: no bypass.** `buf_ready` depends on the registered count only.

**Errors**
- `err_o` sets if a transfer would make `beat_cnt_r` exceed `stream_words_lp` without last.
- `err_o` sets if the header of the locked requester changes mid-message (compared to the latched header).
- `err_o` clears only on reset. On error, data still flows unchanged.

**Wrap-around**
- `rr_ptr_r` wraps from `num_req_p-1` to 0.
- `beat_cnt_r` width is `BSG_SAFE_CLOG2(stream_words_lp+1)`.

## Timing
- Reset (async, `reset_n_i=0`) values: state `e_idle`, `rr_ptr_r=0`, buffer empty, `out_v_o=0`, `out_last_o=0`, `out_src_o=0`, `err_o=0`, `in_ready_and_o=0`.
- Mid-message reset discards the lock and all buffered beats. Requesters must restart their messages.
- `in_ready_and_o` is combinational from state, `in_v_i`, and registered buffer count. It never depends on `out_ready_and_i`.
- Latency is 1 cycle: a beat accepted in cycle N appears on `out_*` in cycle N+1 if the buffer was empty.
- Throughput is 1 beat/cycle while downstream is always ready.
- Arbitration adds no bubble between messages: a new winner may transfer in the cycle after the previous last.
- Outputs are stable while `out_v_o & ~out_ready_and_i`.

## Structure
- `bp_me_pkg` holds the `bp_me_stream_arb_state_e` enum {`e_idle`, `e_locked`}.
- Header structs come from `declare_bp_bedrock_mem_if`.
- Sub-module `bp_me_stream_arb_buffer`: parameterized width, two entries, async active-low reset, ready/valid.
- The round-robin pick is an inline priority-rotate. The FSM, counter and error logic live in the top module.

## Test plan
- **Single-beat alternation:** req0 and req1 both valid, each with last=1, downstream always ready → `out_src_o` sequence 0,1,0,1 with no idle cycles. The first beat appears one cycle after reset release.
- **Lock:** req1 sends a 4-beat message (64B on 128-bit beats); req0 is valid from beat 2 → all 4 req1 beats are contiguous on output, then req0 follows. `in_ready_and_o[0]=0` throughout.
- **Backpressure:** `out_ready_and_i=0` for 5 cycles → exactly 2 beats are accepted, then `in_ready_and_o=0`. On release, the beats drain in order with stable outputs while stalled.
- **Protocol error:** an 8-beat-capable block receives 9 beats without last → `err_o` rises on the 9th transfer and stays high.
- **Header change:** the locked requester changes its header mid-message → `err_o` rises on that transfer and stays high.
- **Async reset mid-message:** assert `reset_n_i` during beat 2 of 4 → `out_v_o=0` and `err_o=0` immediately. After release, req0 wins first (`rr_ptr_r=0`).
